// File: rtl/somador_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// operation-select constants.
package somador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SOMANDO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam logic MODO_SOMA = 1'b0;
    localparam logic MODO_SUB  = 1'b1;

endpackage

// File: rtl/somador_serial_soma1bit.sv
// Single-bit full adder cell, reused every cycle by the serial adder.
module soma1bit (
    input  logic a,
    input  logic b,
    input  logic te,
    output logic s,
    output logic ts
);

    assign s  = a ^ b ^ te;
    assign ts = (a & b) | (te & (a ^ b));

endmodule

// File: rtl/somador_serial.sv
// Bit-serial adder/subtractor: one full-adder cell processes one operand bit
// per cycle, LSB first, and the (N+1)-bit result is flagged by a pronto pulse.
module somador_serial
    import somador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         TE,
    input  logic         modo,
    output logic         ocupado,
    output logic         pronto,
    output logic [N:0]   resultado
);

    // One extra bit so that the terminal count N-1 fits even when N=1.
    localparam int CW = $clog2(N) + 1;

    estado_t        estado, prox_estado;
    logic [N-1:0]   op_a, op_b;
    logic [N-1:0]   parcial, parcial_novo;
    logic           carry;
    logic [CW-1:0]  cont;
    logic           bit_soma, carry_novo;
    logic           ultimo_bit;

    soma1bit celula (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .te (carry),
        .s  (bit_soma),
        .ts (carry_novo)
    );

    generate
        if (N == 1) begin : g_parcial_1
            assign parcial_novo = bit_soma;
        end else begin : g_parcial_n
            assign parcial_novo = {bit_soma, parcial[N-1:1]};
        end
    endgenerate

    assign ultimo_bit = (cont == CW'(N - 1));

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (inicio)     prox_estado = SOMANDO;
            SOMANDO: if (ultimo_bit) prox_estado = FIM;
            FIM:                     prox_estado = OCIOSO;
            default:                 prox_estado = OCIOSO;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            estado  <= prox_estado;
            ocupado <= (prox_estado != OCIOSO);
            pronto  <= (prox_estado == FIM);
        end
    end

    // NOTE: all datapath registers are reset so an aborted operation leaves
    // no residue in the operands, carry or counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            cont      <= '0;
            parcial   <= '0;
            resultado <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        op_a    <= A;
                        op_b    <= (modo == MODO_SUB) ? ~B : B;
                        carry   <= (modo == MODO_SUB) ? 1'b1 : TE;
                        cont    <= '0;
                        parcial <= '0;
                    end
                end
                SOMANDO: begin
                    op_a    <= op_a >> 1;
                    op_b    <= op_b >> 1;
                    carry   <= carry_novo;
                    parcial <= parcial_novo;
                    cont    <= cont + 1'b1;
                    if (ultimo_bit)
                        resultado <= {carry_novo, parcial_novo};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial: vector table at N=8 plus hand-written
// protocol, reset-abort and N=1 throughput sequences.
module tb_somador_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       inicio, te, modo;
    logic [7:0] a, b;
    logic       ocupado, pronto;
    logic [8:0] resultado;

    logic       inicio1, a1, b1, te1, modo1;
    logic       ocupado1, pronto1;
    logic [1:0] resultado1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    somador_serial #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .inicio(inicio), .A(a), .B(b), .TE(te),
        .modo(modo), .ocupado(ocupado), .pronto(pronto), .resultado(resultado)
    );

    somador_serial #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .inicio(inicio1), .A(a1), .B(b1), .TE(te1),
        .modo(modo1), .ocupado(ocupado1), .pronto(pronto1), .resultado(resultado1)
    );

    typedef struct {
        string      nome;
        logic [7:0] va;
        logic [7:0] vb;
        logic       vte;
        logic       vmodo;
        logic [8:0] esperado;
    } vetor_t;

    vetor_t vetores[5];

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual === esperado) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
    endtask

    // Issue one operation on the N=8 instance and follow it to completion.
    task automatic run_op(input string nome, input logic [7:0] va, input logic [7:0] vb,
                          input logic vte, input logic vmodo, input logic [8:0] esp);
        int         ciclo;
        logic [8:0] anterior;
        anterior = resultado;
        a = va; b = vb; te = vte; modo = vmodo; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        a = 8'($urandom); b = 8'($urandom); te = 1'($urandom); modo = 1'($urandom);
        ciclo = 1;
        check({nome, " ocupado after accept"}, ocupado, 1);
        while (!pronto && ciclo < 40) begin
            if (ciclo == 8) check({nome, " resultado held"}, resultado, anterior);
            @(posedge clk); #1;
            ciclo++;
        end
        check({nome, " latency"}, ciclo, 9);
        check({nome, " resultado"}, resultado, esp);
        @(posedge clk); #1;
        check({nome, " pronto falls"}, pronto, 0);
        check({nome, " ocupado falls"}, ocupado, 0);
        check({nome, " resultado kept"}, resultado, esp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ciclo;
        int   pulsos;
        logic mudou;

        vetores[0] = '{"add 200+100",  8'd200, 8'd100, 1'b0, 1'b0, 9'h12C};
        vetores[1] = '{"add 255+255+1", 8'd255, 8'd255, 1'b1, 1'b0, 9'h1FF};
        vetores[2] = '{"add 0+0",      8'd0,   8'd0,   1'b0, 1'b0, 9'h000};
        vetores[3] = '{"sub 100-30",   8'd100, 8'd30,  1'b1, 1'b1, 9'h146};
        vetores[4] = '{"sub 50-80",    8'd50,  8'd80,  1'b0, 1'b1, 9'h0E2};

        // Reset with random inputs, including start requests.
        rst = 1'b1;
        repeat (2) begin
            inicio = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            te = 1'($urandom); modo = 1'($urandom);
            inicio1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
            te1 = 1'($urandom); modo1 = 1'($urandom);
            @(posedge clk); #1;
        end
        check("reset resultado", resultado, 9'h000);
        check("reset pronto", pronto, 0);
        check("reset ocupado", ocupado, 0);
        check("reset n1 resultado", resultado1, 2'b00);
        check("reset n1 ocupado", ocupado1, 0);

        rst = 1'b0; inicio = 1'b0; inicio1 = 1'b0;
        mudou = 1'b0;
        repeat (20) begin
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            if (pronto || ocupado || resultado != 9'h000) mudou = 1'b1;
        end
        check("idle no change", mudou, 0);

        foreach (vetores[i])
            run_op(vetores[i].nome, vetores[i].va, vetores[i].vb,
                   vetores[i].vte, vetores[i].vmodo, vetores[i].esperado);

        // Start requests during SOMANDO and FIM must be ignored.
        a = 8'd10; b = 8'd20; te = 1'b0; modo = 1'b0; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        ciclo = 1;
        while (!pronto && ciclo < 40) begin
            if (ciclo == 3) begin
                inicio = 1'b1; a = 8'd99; b = 8'd1;
            end else begin
                inicio = 1'b0;
            end
            @(posedge clk); #1;
            ciclo++;
        end
        check("protocol latency", ciclo, 9);
        check("protocol resultado", resultado, 9'h01E);
        inicio = 1'b1; a = 8'd77; b = 8'd77;
        @(posedge clk); #1;
        inicio = 1'b0;
        check("protocol fim ocupado", ocupado, 0);
        check("protocol fim pronto", pronto, 0);
        check("protocol resultado kept", resultado, 9'h01E);
        @(posedge clk); #1;
        check("protocol no restart", ocupado, 0);

        // Reset four cycles into an operation.
        a = 8'd3; b = 8'd4; te = 1'b0; modo = 1'b0; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort busy before reset", ocupado, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort resultado", resultado, 9'h000);
        check("abort ocupado", ocupado, 0);
        check("abort pronto", pronto, 0);
        mudou = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (pronto || ocupado) mudou = 1'b1;
        end
        check("abort no pronto", mudou, 0);

        run_op("add 5+7", 8'd5, 8'd7, 1'b0, 1'b0, 9'h00C);

        // N=1 single operation.
        a1 = 1'b1; b1 = 1'b1; te1 = 1'b1; modo1 = 1'b0; inicio1 = 1'b1;
        @(posedge clk); #1;
        inicio1 = 1'b0;
        check("n1 cycle1 pronto", pronto1, 0);
        check("n1 cycle1 ocupado", ocupado1, 1);
        @(posedge clk); #1;
        check("n1 cycle2 pronto", pronto1, 1);
        check("n1 resultado", resultado1, 2'b11);
        @(posedge clk); #1;
        check("n1 back to idle", ocupado1, 0);

        // N=1 back-to-back with inicio held: 1-1 gives 2'b10 every 3 cycles.
        a1 = 1'b1; b1 = 1'b1; te1 = 1'b0; modo1 = 1'b1; inicio1 = 1'b1;
        pulsos = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (pronto1) begin
                check("n1 pulse position", i, 2 + 3 * pulsos);
                check("n1 pulse resultado", resultado1, 2'b10);
                pulsos++;
            end
        end
        inicio1 = 1'b0;
        check("n1 pulse count", pulsos, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
